alu_issue_ctrl: RTL and testbench

//  Issue/configuration stage in front of the RV32I ALU. Accepts one decoded-instruction slot
//  (instr, pc, rs1/rs2 data) per valid/ready handshake. Generates the immediate, selects the

---
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the RV32I ALU: decodes one instruction slot per handshake into
// registered ALU operands, ALU control, immediate and bookkeeping fields.
module alu_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode_reg,
    output logic [3:0]       ALUControl_reg,
    output logic [XLEN-1:0]  SrcA,
    output logic [XLEN-1:0]  SrcB,
    output logic [XLEN-1:0]  imm_reg,
    output logic [XLEN-1:0]  pc_reg,
    output logic [4:0]       rd_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
    slot_state_t state;

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            is_shift;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            legal;
    logic [3:0]      ctrl_n;
    logic [XLEN-1:0] a_n, b_n, imm_n;
    logic            accept;

    assign op       = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Valid/ready: a slot moves on any cycle where valid and ready are both high; the
    // producer holds its payload stable until that happens.
    assign out_valid = (state == FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        legal  = 1'b1;
        ctrl_n = 4'b0000;
        a_n    = rs1_data;
        b_n    = imm_i;
        imm_n  = imm_i;
        case (op)
            OP_R: begin
                b_n    = is_shift ? {27'b0, rs2_data[4:0]} : rs2_data;
                imm_n  = '0;
                ctrl_n = {instr[30] & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
                legal  = (f7 == 7'b0000000) ||
                         ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_IMM: begin
                if (is_shift) b_n = {27'b0, instr[24:20]};
                ctrl_n = {instr[30] & (f3 == 3'b101), f3};
                if (f3 == 3'b001) legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end
            OP_LOAD, OP_JALR: ;
            OP_STORE: begin
                b_n   = imm_s;
                imm_n = imm_s;
            end
            OP_BRANCH: begin
                b_n    = rs2_data;
                imm_n  = imm_b;
                ctrl_n = {1'b1, f3};
                legal  = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_JAL: begin
                a_n   = pc;
                b_n   = imm_j;
                imm_n = imm_j;
            end
            OP_AUIPC: begin
                a_n   = pc;
                b_n   = imm_u;
                imm_n = imm_u;
            end
            OP_LUI: begin
                a_n   = '0;
                b_n   = imm_u;
                imm_n = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    // Flush clears the slot and any pending illegal pulse but leaves the payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= EMPTY;
            illegal        <= 1'b0;
            issue_cnt      <= '0;
            opcode_reg     <= '0;
            ALUControl_reg <= '0;
            SrcA           <= '0;
            SrcB           <= '0;
            imm_reg        <= '0;
            pc_reg         <= '0;
            rd_reg         <= '0;
        end else begin
            if (out_valid && out_ready) issue_cnt <= issue_cnt + CNT_W'(1);
            if (flush) begin
                state   <= EMPTY;
                illegal <= 1'b0;
            end else begin
                illegal <= accept & ~legal;
                if (accept && legal) begin
                    state          <= FULL;
                    opcode_reg     <= op;
                    ALUControl_reg <= ctrl_n;
                    SrcA           <= a_n;
                    SrcB           <= b_n;
                    imm_reg        <= imm_n;
                    pc_reg         <= pc;
                    rd_reg         <= instr[11:7];
                end else if (out_ready) begin
                    state <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenario tasks plus a negedge scoreboard that
// predicts every issued slot, the illegal pulse and the issue counter.
module tb_alu_issue_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   instr = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   rs1_data = '0;
    logic [31:0]   rs2_data = '0;
    logic          in_ready, out_valid, illegal;
    logic [6:0]    opcode_reg;
    logic [3:0]    ALUControl_reg;
    logic [31:0]   SrcA, SrcB, imm_reg, pc_reg;
    logic [4:0]    rd_reg;
    logic [CW-1:0] issue_cnt;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        chk_imm;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] cnt_model = '0;
    logic          ill_exp = 1'b0;
    exp_t          e_m;
    logic          lg_m, hs_m, acc_m;

    alu_issue_ctrl #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .opcode_reg(opcode_reg),
        .ALUControl_reg(ALUControl_reg), .SrcA(SrcA), .SrcB(SrcB), .imm_reg(imm_reg),
        .pc_reg(pc_reg), .rd_reg(rd_reg), .illegal(illegal), .issue_cnt(issue_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference decoder, built per instruction format
    function automatic void model(input logic [31:0] ins, p, r1, r2,
                                  output exp_t e, output logic lg);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] ii, is, ib, iu, ij;
        logic [12:0] b13;
        logic [20:0] j21;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii = $signed(ins) >>> 20;
        is = {ii[31:5], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ib = {{19{b13[12]}}, b13};
        iu = ins & 32'hFFFF_F000;
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ij = {{11{j21[20]}}, j21};
        e.op = op; e.pc = p; e.rd = ins[11:7]; e.ctrl = 4'b0000;
        e.a = r1; e.b = ii; e.imm = ii; e.chk_imm = 1'b1; lg = 1'b1;
        case (op)
            7'b0110011: begin
                lg = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                e.ctrl = {f7 == 7'h20, f3};
                e.b = (f3 == 3'b001 || f3 == 3'b101) ? (r2 & 32'h1F) : r2;
                e.chk_imm = 1'b0;
            end
            7'b0010011: begin
                e.ctrl = {1'b0, f3};
                if (f3 == 3'b001) begin
                    lg = (f7 == 7'h00); e.b = {27'b0, ins[24:20]};
                end else if (f3 == 3'b101) begin
                    lg = (f7 == 7'h00) || (f7 == 7'h20); e.b = {27'b0, ins[24:20]};
                    e.ctrl[3] = (f7 == 7'h20);
                end
            end
            7'b0000011, 7'b1100111: ;
            7'b0100011: begin e.b = is; e.imm = is; end
            7'b1100011: begin
                e.b = r2; e.imm = ib; e.ctrl = {1'b1, f3};
                lg = !(f3 == 3'b010 || f3 == 3'b011);
            end
            7'b1101111: begin e.a = p; e.b = ij; e.imm = ij; end
            7'b0010111: begin e.a = p; e.b = iu; e.imm = iu; end
            7'b0110111: begin e.a = 32'h0; e.b = iu; e.imm = iu; end
            default: lg = 1'b0;
        endcase
    endfunction

    // scoreboard: compare before updating the model with this cycle's inputs
    always @(negedge clk) begin
        total++;
        if (out_valid !== (exp_q.size() != 0)) begin
            bad++; $display("FAIL sb_out_valid: got %b want %b", out_valid, exp_q.size() != 0);
        end
        total++;
        if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin
            bad++; $display("FAIL sb_in_ready: got %b want %b", in_ready, (exp_q.size() == 0) || out_ready);
        end
        total++;
        if (illegal !== ill_exp) begin
            bad++; $display("FAIL sb_illegal: got %b want %b", illegal, ill_exp);
        end
        total++;
        if (issue_cnt !== cnt_model) begin
            bad++; $display("FAIL sb_issue_cnt: got %0d want %0d", issue_cnt, cnt_model);
        end
        if (rst) begin
            exp_q.delete(); cnt_model = '0; ill_exp = 1'b0;
        end else begin
            hs_m  = (exp_q.size() != 0) && out_ready;
            acc_m = in_valid && ((exp_q.size() == 0) || out_ready);
            if ((exp_q.size() != 0) && (out_ready || flush)) begin
                e_m = exp_t'(exp_q.pop_front());
                if (out_ready) begin
                    total++;
                    if ({opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg} !==
                        {e_m.op, e_m.ctrl, e_m.a, e_m.b, e_m.pc, e_m.rd}) begin
                        bad++;
                        $display("FAIL sb_payload: got op=%h ctrl=%h a=%h b=%h pc=%h rd=%0d want op=%h ctrl=%h a=%h b=%h pc=%h rd=%0d",
                                 opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg,
                                 e_m.op, e_m.ctrl, e_m.a, e_m.b, e_m.pc, e_m.rd);
                    end
                    if (e_m.chk_imm) begin
                        total++;
                        if (imm_reg !== e_m.imm) begin
                            bad++; $display("FAIL sb_imm: got %h want %h", imm_reg, e_m.imm);
                        end
                    end
                end
            end
            if (hs_m) cnt_model = cnt_model + 4'd1;
            ill_exp = 1'b0;
            if (acc_m && !flush) begin
                model(instr, pc, rs1_data, rs2_data, e_m, lg_m);
                if (lg_m) exp_q.push_back(EW'(e_m));
                else ill_exp = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, p, a, b);
        in_valid = 1'b1; instr = i; pc = p; rs1_data = a; rs2_data = b;
    endtask

    task automatic idle();
        in_valid = 1'b0; instr = $urandom();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b1100111;
            4: r[6:0] = 7'b0100011;
            5: r[6:0] = 7'b1100011;
            6: r[6:0] = 7'b1101111;
            7: r[6:0] = 7'b0010111;
            8: r[6:0] = 7'b0110111;
            default: r[6:0] = 7'b1111111;
        endcase
        if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++;
        if (out_valid !== 1'b0 || illegal !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got valid=%b illegal=%b want 0 0", out_valid, illegal);
        end
        total++;
        if (issue_cnt !== '0) begin
            bad++; $display("FAIL reset_cnt: got %0d want 0", issue_cnt);
        end
        total++;
        if ({opcode_reg, ALUControl_reg, SrcA, SrcB, imm_reg, pc_reg, rd_reg} !== '0) begin
            bad++; $display("FAIL reset_payload: got op=%h ctrl=%h a=%h b=%h imm=%h pc=%h rd=%h want all 0",
                            opcode_reg, ALUControl_reg, SrcA, SrcB, imm_reg, pc_reg, rd_reg);
        end
        rst = 1'b0;
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(32'h4020_8033, 32'h40, 32'd5, 32'd3);
        tick(); idle();
        total++;
        if (out_valid !== 1'b1 || ALUControl_reg !== 4'b1000 || SrcA !== 32'd5 ||
            SrcB !== 32'd3 || opcode_reg !== 7'b0110011) begin
            bad++; $display("FAIL sub: got v=%b ctrl=%b a=%0d b=%0d op=%b want 1 1000 5 3 0110011",
                            out_valid, ALUControl_reg, SrcA, SrcB, opcode_reg);
        end
        tick();
    endtask

    task automatic test_shift();
        out_ready = 1'b1;
        drive(32'h4041_5093, 32'h44, 32'h8000_0000, 32'h77);
        tick();
        total++;
        if (ALUControl_reg !== 4'b1101 || SrcB !== 32'd4 || SrcA !== 32'h8000_0000) begin
            bad++; $display("FAIL srai: got ctrl=%b b=%h a=%h want 1101 4 80000000", ALUControl_reg, SrcB, SrcA);
        end
        drive(32'h0020_9093, 32'h48, 32'd1, 32'hFFFF_FFFF);
        tick();
        total++;
        if (ALUControl_reg !== 4'b0001 || SrcB !== 32'd2) begin
            bad++; $display("FAIL slli: got ctrl=%b b=%h want 0001 2", ALUControl_reg, SrcB);
        end
        drive(32'h0020_90B3, 32'h4C, 32'd1, 32'hFFFF_FFE3);
        tick(); idle();
        total++;
        if (ALUControl_reg !== 4'b0001 || SrcB !== 32'd3) begin
            bad++; $display("FAIL sll: got ctrl=%b b=%h want 0001 3", ALUControl_reg, SrcB);
        end
        tick();
    endtask

    task automatic test_branch_jump();
        out_ready = 1'b1;
        drive(32'h0020_8463, 32'h100, 32'd7, 32'd9);
        tick();
        total++;
        if (ALUControl_reg !== 4'b1000 || SrcB !== 32'd9 || imm_reg !== 32'd8 || pc_reg !== 32'h100) begin
            bad++; $display("FAIL beq: got ctrl=%b b=%h imm=%h pc=%h want 1000 9 8 100",
                            ALUControl_reg, SrcB, imm_reg, pc_reg);
        end
        drive(32'h0080_006F, 32'h200, 32'd7, 32'd9);
        tick(); idle();
        total++;
        if (ALUControl_reg !== 4'b0000 || SrcA !== 32'h200 || SrcB !== 32'd8) begin
            bad++; $display("FAIL jal: got ctrl=%b a=%h b=%h want 0000 200 8", ALUControl_reg, SrcA, SrcB);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [111:0]  snap;
        logic [CW-1:0] cnt0;
        out_ready = 1'b0;
        drive(32'h0050_0093, 32'h300, 32'd10, 32'd20);
        tick();
        snap = {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg};
        cnt0 = issue_cnt;
        drive(32'h0020_81B3, 32'h304, 32'd1, 32'd2);
        #1;
        repeat (3) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg} !== snap) begin
                bad++; $display("FAIL bp_hold: got v=%b payload=%h want 1 %h", out_valid,
                                {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg}, snap);
            end
        end
        out_ready = 1'b1;
        tick();
        drive(32'h1234_5237, 32'h308, 32'd0, 32'd0);
        tick(); idle();
        tick();
        total++;
        if (issue_cnt !== cnt0 + 4'd3 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain: got cnt=%0d v=%b want %0d 0", issue_cnt, out_valid, cnt0 + 4'd3);
        end
    endtask

    task automatic test_illegal();
        logic [31:0]   ill_tab[4];
        logic [CW-1:0] cnt0;
        ill_tab = '{32'hFFFF_FFFF, 32'h0020_A463, 32'h4020_90B3, 32'h4020_9093};
        out_ready = 1'b0;
        foreach (ill_tab[k]) begin
            cnt0 = issue_cnt;
            drive(ill_tab[k], 32'h600, $urandom(), $urandom());
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL ill_in_ready: instr=%h got %b want 1", ill_tab[k], in_ready);
            end
            tick(); idle();
            total++;
            if (illegal !== 1'b1 || out_valid !== 1'b0 || issue_cnt !== cnt0) begin
                bad++; $display("FAIL ill_pulse: instr=%h got ill=%b v=%b cnt=%0d want 1 0 %0d",
                                ill_tab[k], illegal, out_valid, issue_cnt, cnt0);
            end
            tick();
            total++;
            if (illegal !== 1'b0) begin
                bad++; $display("FAIL ill_one_cycle: got %b want 0", illegal);
            end
        end
        out_ready = 1'b1;
        drive(32'h0050_0093, 32'h610, 32'd1, 32'd2);
        tick();
        drive(32'hFFFF_FFFF, 32'h614, 32'd1, 32'd2);
        tick(); idle();
        total++;
        if (illegal !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL ill_full: got ill=%b v=%b want 1 0", illegal, out_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [111:0]  snap;
        logic [CW-1:0] cnt0;
        out_ready = 1'b0;
        drive(32'h00A0_0113, 32'h400, 32'd3, 32'd4);
        tick();
        snap = {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg};
        flush = 1'b1;
        drive(32'h0020_81B3, 32'h404, 32'd8, 32'd9);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick(); flush = 1'b0; idle();
        total++;
        if (out_valid !== 1'b0 || {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg} !== snap) begin
            bad++; $display("FAIL flush_hold: got v=%b payload=%h want 0 %h", out_valid,
                            {opcode_reg, ALUControl_reg, SrcA, SrcB, pc_reg, rd_reg}, snap);
        end
        drive(32'h00A0_0113, 32'h408, 32'd5, 32'd6);
        tick();
        cnt0 = issue_cnt;
        out_ready = 1'b1; flush = 1'b1;
        drive(32'hFFFF_FFFF, 32'h40C, 32'd0, 32'd0);
        tick(); flush = 1'b0; idle();
        total++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || issue_cnt !== cnt0 + 4'd1) begin
            bad++; $display("FAIL flush_handshake: got v=%b ill=%b cnt=%0d want 0 0 %0d",
                            out_valid, illegal, issue_cnt, cnt0 + 4'd1);
        end
    endtask

    task automatic test_rst_hold();
        out_ready = 1'b0;
        drive(32'h0050_0093, 32'h500, 32'h11, 32'h22);
        tick(); idle();
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL rsthold_pre: got v=%b want 1", out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || issue_cnt !== '0 ||
            {opcode_reg, ALUControl_reg, SrcA, SrcB, imm_reg, pc_reg, rd_reg} !== '0) begin
            bad++; $display("FAIL rsthold: got v=%b ill=%b cnt=%0d a=%h b=%h pc=%h want all 0",
                            out_valid, illegal, issue_cnt, SrcA, SrcB, pc_reg);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] imm_v;
        logic [4:0]  rd_v;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            imm_v = 12'($urandom_range(0, 4095));
            rd_v  = 5'($urandom_range(1, 31));
            drive({imm_v, 5'd2, 3'b000, rd_v, 7'b0010011}, 32'h700 + 32'(4 * k), $urandom(), $urandom());
            tick();
            if (k == 15) begin
                total++;
                if (issue_cnt !== 4'd15) begin
                    bad++; $display("FAIL wrap_pre: got %0d want 15", issue_cnt);
                end
            end
        end
        idle();
        tick();
        total++;
        if (issue_cnt !== 4'd0) begin
            bad++; $display("FAIL wrap: got %0d want 0", issue_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = rand_instr();
            pc        = $urandom() & 32'hFFFF_FFFC;
            rs1_data  = $urandom();
            rs2_data  = $urandom();
            tick();
        end
        flush = 1'b0; idle(); out_ready = 1'b1;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_shift();
        test_branch_jump();
        test_backpressure();
        test_illegal();
        test_flush();
        test_rst_hold();
        test_wrap();
        test_random();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
